// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: state encodings, funct3 size codes,
// and the decode-time legality checks.
package lsu_pkg;

  localparam int unsigned LSU_TMO_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_WAIT_R = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } LsuSize_e;

  // Unsigned sizes exist only for loads; everything else outside b/h/w is illegal.
  function automatic logic lsu_f3_bad(input logic st, input logic [2:0] f3);
    logic bad;
    case (f3)
      LS_B, LS_H, LS_W: bad = 1'b0;
      LS_BU, LS_HU:     bad = st;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and lane replication, plus load extraction
// with sign/zero extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld_data
);

  logic [31:0] shifted_s;
  logic        sext_s;

  // Lane selection by access size; funct3[2] marks the zero-extending loads
  always_comb begin
    shifted_s = i_rdata >> {i_off, 3'b000};
    sext_s    = ~i_funct3[2];
    o_be      = 4'b0000;
    o_wdata   = 32'h0000_0000;
    o_ld_data = 32'h0000_0000;
    case (i_funct3[1:0])
      2'b00: begin
        o_be      = 4'b0001 << i_off;
        o_wdata   = {4{i_st_data[7:0]}};
        o_ld_data = {{24{sext_s & shifted_s[7]}}, shifted_s[7:0]};
      end
      2'b01: begin
        o_be      = 4'b0011 << i_off;
        o_wdata   = {2{i_st_data[15:0]}};
        o_ld_data = {{16{sext_s & shifted_s[15]}}, shifted_s[15:0]};
      end
      2'b10: begin
        o_be      = 4'b1111;
        o_wdata   = i_st_data;
        o_ld_data = shifted_s;
      end
      default: begin
        o_be      = 4'b0000;
        o_wdata   = 32'h0000_0000;
        o_ld_data = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts a decoded memory op, runs req/gnt/rvalid on the data bus
// with a timeout, and returns extended load data with fault flags on a one-cycle done.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lsu_valid,
  input  logic        i_st_mem,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_ld_data,
  output logic        o_misalign,
  output logic        o_bus_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [LSU_TMO_W-1:0] TMO_LAST = LSU_TMO_W'(TIMEOUT_CYC - 1);

  logic [1:0]           state_q, state_d;
  logic [LSU_TMO_W-1:0] cnt_q, cnt_d;
  logic                 st_q, st_d;
  logic [2:0]           f3_q, f3_d;
  logic [31:0]          addr_q, addr_d;
  logic [3:0]           be_q, be_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          ld_data_q, ld_data_d;
  logic                 misalign_q, misalign_d;
  logic                 bus_err_q, bus_err_d;

  logic [3:0]  st_be_s;
  logic [31:0] st_wdata_s;
  logic [31:0] ld_ext_s;
  logic [31:0] st_ld_unused_s;
  logic [3:0]  ld_be_unused_s;
  logic [31:0] ld_wdata_unused_s;

  // Store lanes come from the live request so they can be latched at accept time.
  lsu_align u_align_st (
    .i_funct3  (i_funct3),
    .i_off     (i_addr[1:0]),
    .i_st_data (i_st_data),
    .i_rdata   (32'h0000_0000),
    .o_be      (st_be_s),
    .o_wdata   (st_wdata_s),
    .o_ld_data (st_ld_unused_s)
  );

  lsu_align u_align_ld (
    .i_funct3  (f3_q),
    .i_off     (addr_q[1:0]),
    .i_st_data (32'h0000_0000),
    .i_rdata   (i_mem_rdata),
    .o_be      (ld_be_unused_s),
    .o_wdata   (ld_wdata_unused_s),
    .o_ld_data (ld_ext_s)
  );

  // Access sequencing, timeout counting and result capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    st_d       = st_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    ld_data_d  = ld_data_q;
    misalign_d = misalign_q;
    bus_err_d  = bus_err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_lsu_valid) begin
          st_d    = i_st_mem;
          f3_d    = i_funct3;
          addr_d  = i_addr;
          be_d    = st_be_s;
          wdata_d = st_wdata_s;
          if (lsu_f3_bad(i_st_mem, i_funct3)) begin
            bus_err_d = 1'b1;
            state_d   = ST_DONE;
          end else if (lsu_misaligned(i_funct3, i_addr[1:0])) begin
            misalign_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            cnt_d   = {LSU_TMO_W{1'b0}};
            state_d = ST_REQ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + {{(LSU_TMO_W-1){1'b0}}, 1'b1};
        // A load granted in the last budget cycle cannot see rvalid in time.
        if (i_mem_gnt && st_q) begin
          state_d = ST_DONE;
        end else if (cnt_q == TMO_LAST) begin
          bus_err_d = 1'b1;
          state_d   = ST_DONE;
        end else if (i_mem_gnt) begin
          state_d = ST_WAIT_R;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT_R: begin
        cnt_d = cnt_q + {{(LSU_TMO_W-1){1'b0}}, 1'b1};
        if (i_mem_rvalid) begin
          ld_data_d = ld_ext_s;
          state_d   = ST_DONE;
        end else if (cnt_q == TMO_LAST) begin
          bus_err_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          state_d = ST_WAIT_R;
        end
      end
      ST_DONE: begin
        ld_data_d  = 32'h0000_0000;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {LSU_TMO_W{1'b0}};
      st_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= 32'h0000_0000;
      be_q       <= 4'b0000;
      wdata_q    <= 32'h0000_0000;
      ld_data_q  <= 32'h0000_0000;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      st_q       <= st_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      ld_data_q  <= ld_data_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign o_stall     = i_lsu_valid & (state_q != ST_DONE);
  assign o_done      = (state_q == ST_DONE);
  assign o_ld_data   = ld_data_q;
  assign o_misalign  = misalign_q;
  assign o_bus_err   = bus_err_q;
  assign o_mem_req   = (state_q == ST_REQ);
  assign o_mem_we    = o_mem_req & st_q;
  assign o_mem_addr  = {addr_q[31:2], 2'b00};
  assign o_mem_be    = o_mem_req ? be_q : 4'b0000;
  assign o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized ops against a
// cycle-count/arithmetic reference model of the access rules.
module tb_lsu;

  localparam int T = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid, st_mem;
  logic [2:0]  funct3;
  logic [31:0] addr, st_data;
  logic        stall, done, misalign, bus_err;
  logic [31:0] ld_data;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT_CYC(T)) dut (
    .i_clk(clk), .i_rst(rst), .i_lsu_valid(lsu_valid), .i_st_mem(st_mem),
    .i_funct3(funct3), .i_addr(addr), .i_st_data(st_data),
    .o_stall(stall), .o_done(done), .o_ld_data(ld_data),
    .o_misalign(misalign), .o_bus_err(bus_err),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
    .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    else if (f3[1:0] == 2'b01) return 2;
    else return 4;
  endfunction

  function automatic bit is_bad(input logic st, input logic [2:0] f3);
    return (f3 == 3'd3) || (f3 >= 3'd6) || (st && f3[2]);
  endfunction

  function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
    int n = nbytes(f3);
    return (a % n) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int v = ((1 << nbytes(f3)) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int n = nbytes(f3);
    if (n == 1) return d[7:0] * 32'h0101_0101;
    else if (n == 2) return d[15:0] * 32'h0001_0001;
    else return d;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] rd);
    int n = nbytes(f3);
    int bits = 8 * n;
    logic [31:0] v = rd >> (8 * (a % 4));
    logic [31:0] mask;
    if (n == 4) return v;
    mask = (32'h1 << bits) - 32'h1;
    v = v & mask;
    if (!f3[2] && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  // One complete access: g = REQ cycles before gnt, r = cycles from gnt to rvalid.
  task automatic run_op(input string nm, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input int g, input int r, input logic [31:0] rd);
    int  exp_cyc;
    bit  e_mis = 0, e_err = 0, seen_req = 0, got_done = 0;
    logic [31:0] e_ld = 32'h0;
    if (is_bad(st, f3)) begin
      e_err = 1; exp_cyc = 2;
    end else if (is_mis(f3, a)) begin
      e_mis = 1; exp_cyc = 2;
    end else if (st) begin
      if (g >= T) begin e_err = 1; exp_cyc = T + 2; end
      else exp_cyc = g + 3;
    end else begin
      if (g + r >= T) begin e_err = 1; exp_cyc = T + 2; end
      else begin exp_cyc = g + r + 3; e_ld = m_ld(f3, a, rd); end
    end

    @(negedge clk);
    lsu_valid = 1'b1; st_mem = st; funct3 = f3; addr = a; st_data = d;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    for (int c = 1; c <= T + 6; c++) begin
      if (c >= 2) begin
        mem_gnt    = (c - 2 == g);
        mem_rvalid = !st && (c - 2 == g + r);
        mem_rdata  = mem_rvalid ? rd : $urandom;
      end
      #1;
      if (mem_req && !seen_req) begin
        seen_req = 1;
        chk_eq({nm, ".addr"}, mem_addr, {a[31:2], 2'b00});
        chk_eq({nm, ".we"}, {31'b0, mem_we}, {31'b0, st});
        chk_eq({nm, ".be"}, {28'b0, mem_be}, {28'b0, m_be(f3, a)});
        if (st) chk_eq({nm, ".wdata"}, mem_wdata, m_wdata(f3, d));
      end
      if (done) begin
        got_done = 1;
        chk_eq({nm, ".cycle"}, c, exp_cyc);
        chk_eq({nm, ".misalign"}, {31'b0, misalign}, {31'b0, e_mis});
        chk_eq({nm, ".bus_err"}, {31'b0, bus_err}, {31'b0, e_err});
        chk_eq({nm, ".ld_data"}, ld_data, e_ld);
        chk_eq({nm, ".stall_done"}, {31'b0, stall}, 32'h0);
        break;
      end else begin
        chk_eq({nm, ".stall"}, {31'b0, stall}, 32'h1);
      end
      @(negedge clk);
    end
    if (!got_done) chk_eq({nm, ".done_seen"}, 32'h0, 32'h1);
    chk_eq({nm, ".req_seen"}, {31'b0, seen_req}, {31'b0, !(e_mis || e_err) || (exp_cyc == T + 2)});
    lsu_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic chk_quiet(input string nm);
    chk_eq({nm, ".req"}, {31'b0, mem_req}, 32'h0);
    chk_eq({nm, ".done"}, {31'b0, done}, 32'h0);
    chk_eq({nm, ".stall"}, {31'b0, stall}, 32'h0);
    chk_eq({nm, ".flags"}, {30'b0, misalign, bus_err}, 32'h0);
    chk_eq({nm, ".ld_data"}, ld_data, 32'h0);
    chk_eq({nm, ".we_be"}, {27'b0, mem_we, mem_be}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; lsu_valid = 1'b0; st_mem = 1'b0; funct3 = 3'b000;
    addr = 32'h0; st_data = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    @(negedge clk); @(negedge clk);
    chk_quiet("reset");
    chk_eq("reset.addr", mem_addr, 32'h0);
    chk_eq("reset.wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    run_op("sw",   1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1, 32'h0);
    run_op("sb",   1'b1, 3'b000, 32'h203, 32'h000000A5, 0, 1, 32'h0);
    run_op("lb",   1'b0, 3'b000, 32'h11,  32'h0,        0, 2, 32'h0000F000);
    run_op("lbu",  1'b0, 3'b100, 32'h11,  32'h0,        0, 2, 32'h0000F000);
    run_op("lh_mis", 1'b0, 3'b001, 32'h3, 32'h0,        0, 1, 32'h0);
    run_op("lhu",  1'b0, 3'b101, 32'h2,   32'h0,        1, 1, 32'h8001_1234);
    run_op("lw",   1'b0, 3'b010, 32'h40,  32'h0,        2, 1, 32'hCAFE_F00D);
    run_op("f3_011", 1'b0, 3'b011, 32'h0, 32'h0,        0, 1, 32'h0);
    run_op("sbu_bad", 1'b1, 3'b100, 32'h0, 32'h0,       0, 1, 32'h0);
    run_op("sh_edge", 1'b1, 3'b001, 32'h2, 32'h1234_5678, T - 1, 1, 32'h0);

    // Timeout with gnt never given, then a late response must not complete anything
    run_op("lw_tmo", 1'b0, 3'b010, 32'h80, 32'h0, 1000, 1, 32'h0);
    @(negedge clk);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    chk_quiet("late_rvalid");

    for (int i = 0; i < 80; i++) begin
      run_op("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom_range(0, T + 1), $urandom_range(1, 3), $urandom);
    end

    // Reset while waiting for read data
    @(negedge clk);
    lsu_valid = 1'b1; st_mem = 1'b0; funct3 = 3'b010; addr = 32'h44;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    chk_eq("rst_mid.in_wait", {31'b0, mem_req}, 32'h0);
    rst = 1'b1; lsu_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_quiet("rst_mid");
    chk_eq("rst_mid.addr", mem_addr, 32'h0);
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk_quiet("rst_mid.rvalid1");
    @(negedge clk);
    #1;
    chk_quiet("rst_mid.rvalid2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
